// File: rtl/mar_mem_ctrl.sv
// Memory address register with a req/ack memory sequencer.
// Loads or steps the address while idle, runs one memory transaction at a time, and flags range/timeout faults.
module mar_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MEM_DEPTH = 512,
    parameter int STRIDE    = 1,
    parameter int AUTO_INC  = 0,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              Clear,
    input  logic              MARIn,
    input  logic              IncIn,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              Read,
    input  logic              Write,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] Address,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W:0]   STRIDE_E    = (ADDR_W + 1)'(STRIDE);
    localparam logic [ADDR_W:0]   DEPTH_E     = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [DATA_W:0]   DEPTH_BUS   = (DATA_W + 1)'(MEM_DEPTH);
    localparam logic [TMR_W-1:0]  TIMEOUT_T   = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
    localparam bit                AUTO_INC_EN = (AUTO_INC != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              ack_exit_q, ack_exit_d;

    logic              load_oor_s;
    logic              start_conflict_s;

    // The sum is one bit wider than the address so the step never overflows before the modulo.
    function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] sum;
        sum      = {1'b0, a} + STRIDE_E;
        inc_wrap = ADDR_W'(sum % DEPTH_E);
    endfunction

    assign load_oor_s       = MARIn && ({1'b0, BusMuxOut} >= DEPTH_BUS);
    assign start_conflict_s = Read && Write;

    // Next-state and registered-output computation for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fault_d    = fault_q;
        timer_d    = timer_q;
        ack_exit_d = ack_exit_q;

        case (state_q)
            IDLE: begin
                if (MARIn) begin
                    addr_d = BusMuxOut[ADDR_W-1:0];
                end else if (IncIn) begin
                    addr_d = inc_wrap(addr_q);
                end else begin
                    addr_d = addr_q;
                end

                fault_d = fault_q | load_oor_s | start_conflict_s;

                if (start_conflict_s) begin
                    state_d = IDLE;
                end else if (Read || Write) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = Write;
                    busy_d     = 1'b1;
                    timer_d    = '0;
                    ack_exit_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            REQ: begin
                if (mem_ack) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    done_d     = 1'b1;
                    ack_exit_d = 1'b1;
                end else if (timer_q == TIMEOUT_T) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    done_d     = 1'b1;
                    fault_d    = 1'b1;
                    ack_exit_d = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_we_d = 1'b0;
                // A timed-out transaction leaves the address where it was.
                if (AUTO_INC_EN && ack_exit_q) begin
                    addr_d = inc_wrap(addr_q);
                end else begin
                    addr_d = addr_q;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
                timer_d   = '0;
            end
        endcase
    end

    // State and output registers; Clear drops everything, including an in-flight request, at once.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            timer_q    <= '0;
            ack_exit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            timer_q    <= timer_d;
            ack_exit_q <= ack_exit_d;
        end
    end

    assign Address = addr_q;
    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_mar_mem_ctrl.sv
// Directed bench for mar_mem_ctrl: one auto-incrementing unit-stride instance and one stride-4 instance share stimulus.
module tb_mar_mem_ctrl;

    logic        clk;
    logic        Clear;
    logic        MARIn;
    logic        IncIn;
    logic [31:0] BusMuxOut;
    logic        Read;
    logic        Write;
    logic        mem_ack;

    logic [8:0]  addr_a, addr_b;
    logic        req_a, req_b, we_a, we_b, busy_a, busy_b, done_a, done_b, fault_a, fault_b;

    int n_checks = 0;
    int n_fail   = 0;

    mar_mem_ctrl #(
        .DATA_W(32), .ADDR_W(9), .MEM_DEPTH(512), .STRIDE(1), .AUTO_INC(1), .TIMEOUT(15)
    ) u_dut (
        .clk(clk), .Clear(Clear), .MARIn(MARIn), .IncIn(IncIn), .BusMuxOut(BusMuxOut),
        .Read(Read), .Write(Write), .mem_ack(mem_ack), .Address(addr_a), .mem_req(req_a),
        .mem_we(we_a), .busy(busy_a), .done(done_a), .fault(fault_a)
    );

    mar_mem_ctrl #(
        .DATA_W(32), .ADDR_W(9), .MEM_DEPTH(512), .STRIDE(4), .AUTO_INC(0), .TIMEOUT(15)
    ) u_dut_s4 (
        .clk(clk), .Clear(Clear), .MARIn(MARIn), .IncIn(IncIn), .BusMuxOut(BusMuxOut),
        .Read(Read), .Write(Write), .mem_ack(mem_ack), .Address(addr_b), .mem_req(req_b),
        .mem_we(we_b), .busy(busy_b), .done(done_b), .fault(fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle_clear();
        #3 Clear = 1'b1;
        #1;
        check("clr_addr_a", 32'(addr_a), 32'h0);
        check("clr_addr_b", 32'(addr_b), 32'h0);
        check("clr_req",    32'(req_a),  32'h0);
        check("clr_busy",   32'(busy_a), 32'h0);
        check("clr_fault",  32'(fault_a), 32'h0);
        #1 Clear = 1'b0;
    endtask

    int cnt;
    int guard;

    initial begin
        Clear = 1'b1; MARIn = 1'b0; IncIn = 1'b0; BusMuxOut = 32'h0;
        Read = 1'b0; Write = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        check("rst_addr",  32'(addr_a), 32'h0);
        check("rst_req",   32'(req_a),  32'h0);
        check("rst_we",    32'(we_a),   32'h0);
        check("rst_busy",  32'(busy_a), 32'h0);
        check("rst_done",  32'(done_a), 32'h0);
        check("rst_fault", 32'(fault_a), 32'h0);
        Clear = 1'b0;

        // In-range load
        MARIn = 1'b1; BusMuxOut = 32'h1F5; tick();
        check("load_addr",  32'(addr_a), 32'h1F5);
        check("load_fault", 32'(fault_a), 32'h0);

        // Out-of-range load truncates and faults
        BusMuxOut = 32'h200; tick(); MARIn = 1'b0;
        check("oor_addr",  32'(addr_a), 32'h000);
        check("oor_fault", 32'(fault_a), 32'h1);
        mid_cycle_clear();

        // Increment wrap
        MARIn = 1'b1; BusMuxOut = 32'h1FE; tick(); MARIn = 1'b0;
        IncIn = 1'b1; tick();
        check("inc_s4_wrap", 32'(addr_b), 32'h002);
        check("inc_s1",      32'(addr_a), 32'h1FF);
        tick(); IncIn = 1'b0;
        check("inc_s1_wrap", 32'(addr_a), 32'h000);
        check("inc_s4_2",    32'(addr_b), 32'h006);
        check("inc_fault",   32'(fault_a | fault_b), 32'h0);

        // MARIn wins over IncIn
        MARIn = 1'b1; IncIn = 1'b1; BusMuxOut = 32'h10; tick();
        MARIn = 1'b0; IncIn = 1'b0;
        check("prio_a", 32'(addr_a), 32'h10);
        check("prio_b", 32'(addr_b), 32'h10);

        // Read with ack on third REQ cycle; MARIn during REQ must be ignored
        MARIn = 1'b1; BusMuxOut = 32'h040; tick(); MARIn = 1'b0;
        Read = 1'b1; tick(); Read = 1'b0;
        check("rd_req1",  32'(req_a),  32'h1);
        check("rd_we",    32'(we_a),   32'h0);
        check("rd_busy",  32'(busy_a), 32'h1);
        check("rd_done0", 32'(done_a), 32'h0);
        MARIn = 1'b1; BusMuxOut = 32'h123; tick(); MARIn = 1'b0;
        check("rd_req2",      32'(req_a),  32'h1);
        check("req_mar_hold", 32'(addr_a), 32'h040);
        tick();
        check("rd_req3", 32'(req_a), 32'h1);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("rd_req_off", 32'(req_a),  32'h0);
        check("rd_done",    32'(done_a), 32'h1);
        check("rd_busy_d",  32'(busy_a), 32'h1);
        tick();
        check("rd_done_1cy", 32'(done_a), 32'h0);
        check("rd_busy_end", 32'(busy_a), 32'h0);
        check("rd_autoinc",  32'(addr_a), 32'h041);
        check("rd_noinc_s4", 32'(addr_b), 32'h040);
        check("rd_fault",    32'(fault_a), 32'h0);

        // Write with no ack times out after 16 request cycles
        Write = 1'b1; tick(); Write = 1'b0;
        check("wr_we", 32'(we_a), 32'h1);
        cnt = 0; guard = 0;
        while (req_a && guard < 40) begin
            cnt++; guard++;
            tick();
        end
        check("to_req_cycles", 32'(cnt), 32'd16);
        check("to_done",  32'(done_a),  32'h1);
        check("to_fault", 32'(fault_a), 32'h1);
        tick();
        check("to_done_off", 32'(done_a), 32'h0);
        check("to_busy",     32'(busy_a), 32'h0);
        check("to_addr",     32'(addr_a), 32'h041);
        check("to_we_off",   32'(we_a),   32'h0);

        // Following write completes; fault stays sticky
        Write = 1'b1; mem_ack = 1'b1; tick(); Write = 1'b0;
        check("wr2_req", 32'(req_a), 32'h1);
        check("wr2_we",  32'(we_a),  32'h1);
        tick(); mem_ack = 1'b0;
        check("wr2_done",  32'(done_a),  32'h1);
        check("wr2_req0",  32'(req_a),   32'h0);
        tick();
        check("wr2_addr",   32'(addr_a),  32'h042);
        check("wr2_sticky", 32'(fault_a), 32'h1);
        check("wr2_busy",   32'(busy_a),  32'h0);
        mid_cycle_clear();

        // Read and Write together
        Read = 1'b1; Write = 1'b1; tick(); Read = 1'b0; Write = 1'b0;
        check("rw_req",   32'(req_a),   32'h0);
        check("rw_busy",  32'(busy_a),  32'h0);
        check("rw_fault", 32'(fault_a), 32'h1);
        mid_cycle_clear();

        // Clear during REQ drops request at once; later ack is ignored
        Read = 1'b1; tick(); Read = 1'b0;
        check("cr_req1", 32'(req_a), 32'h1);
        #3 Clear = 1'b1;
        #1;
        check("cr_req_async",  32'(req_a),  32'h0);
        check("cr_busy_async", 32'(busy_a), 32'h0);
        #1 Clear = 1'b0;
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("cr_no_done", 32'(done_a), 32'h0);
        check("cr_no_req",  32'(req_a),  32'h0);
        tick();
        check("cr_no_done2", 32'(done_a), 32'h0);
        check("cr_idle",     32'(busy_a), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
